// File: rtl/rtc_bus_pkg.sv
// Shared types and default constants for the RTC bus transaction sequencer.
// Contents: FSM state enum, operation enum, and default timing constants.
package rtc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int PHASE_LEN_D  = 23;
    localparam int GAP_LEN_D    = 2;
    localparam int SAMPLE_IDX_D = 12;
    localparam int CNT_W        = 5;

endpackage

// File: rtl/rtc_bus_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter (read vs. write).
// Ports:
//   clkW, resetAD      clock, async active-high reset
//   req_rd, req_wr     request levels
//   accept             the pick is taken this cycle; remember it as last winner
//   pick               combinational choice among the active requests
module rr_arb2
    import rtc_bus_pkg::*;
(
    input  logic clkW,
    input  logic resetAD,
    input  logic req_rd,
    input  logic req_wr,
    input  logic accept,
    output op_e  pick
);

    op_e last_winner_q, last_winner_d;

    // On a tie the op that did not win last time goes first. Reset value
    // READ makes a write win the first tie.
    always_comb begin
        pick = OP_RD;
        if (req_wr && (!req_rd || last_winner_q == OP_RD))
            pick = OP_WR;
        last_winner_d = last_winner_q;
        if (accept)
            last_winner_d = pick;
    end

    always_ff @(posedge clkW or posedge resetAD) begin
        if (resetAD) last_winner_q <= OP_RD;
        else         last_winner_q <= last_winner_d;
    end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Transaction controller for the multiplexed address/data RTC bus.
// Each transaction is an address phase, a data phase (both PHASE_LEN cycles
// with enW high), and a GAP_LEN idle gap with enW low so the strobe
// generator's counter returns to 0.
// Ports:
//   clkW, resetAD                  clock, async active-high reset
//   rd_req/rd_addr                 read request (level, held until rd_gnt)
//   wr_req/wr_addr/wr_data         write request (level, held until wr_gnt)
//   rd_gnt, wr_gnt                 one-cycle grant pulses (first ADDR cycle)
//   busy                           grant through last GAP cycle
//   enW, c_ad                      strobe generator enable / address-phase flag
//   bus_out, bus_oe, bus_in        AD bus drive value, enable, readback
//   rd_data, rd_valid              captured read data and its update pulse
//   wr_done                        write completion pulse
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int DW         = 8,
    parameter int PHASE_LEN  = PHASE_LEN_D,
    parameter int GAP_LEN    = GAP_LEN_D,
    parameter int SAMPLE_IDX = SAMPLE_IDX_D
) (
    input  logic          clkW,
    input  logic          resetAD,
    input  logic          rd_req,
    input  logic [DW-1:0] rd_addr,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          rd_gnt,
    output logic          wr_gnt,
    output logic          busy,
    output logic          enW,
    output logic          c_ad,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          wr_done
);

    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] SMP      = CNT_W'(SAMPLE_IDX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [DW-1:0]    addr_q, addr_d, data_q, data_d;
    logic [DW-1:0]    rd_data_q, rd_data_d, bus_out_q, bus_out_d;
    logic             rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
    logic             busy_q, busy_d, enw_q, enw_d, c_ad_q, c_ad_d;
    logic             bus_oe_q, bus_oe_d, rd_valid_q, rd_valid_d;
    logic             wr_done_q, wr_done_d;
    logic             accept;
    op_e              pick;

    rr_arb2 u_arb (
        .clkW    (clkW),
        .resetAD (resetAD),
        .req_rd  (rd_req),
        .req_wr  (wr_req),
        .accept  (accept),
        .pick    (pick)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rd_req || wr_req) begin
                    accept  = 1'b1;
                    op_d    = pick;
                    addr_d  = (pick == OP_WR) ? wr_addr : rd_addr;
                    data_d  = wr_data;
                    state_d = ADDR;
                    cnt_d   = '0;
                end
            end
            ADDR: begin
                if (cnt_q >= PH_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (op_q == OP_RD && cnt_q == SMP)
                    rd_data_d = bus_in;
                if (cnt_q >= PH_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so they are decoded from the state the
        // machine is entering rather than the one it is leaving.
        enw_d      = (state_d == ADDR) || (state_d == DATA);
        c_ad_d     = (state_d == ADDR);
        busy_d     = (state_d != IDLE);
        bus_oe_d   = (state_d == ADDR) || (state_d == DATA && op_d == OP_WR);
        bus_out_d  = '0;
        if (state_d == ADDR)
            bus_out_d = addr_d;
        else if (state_d == DATA && op_d == OP_WR)
            bus_out_d = data_d;
        rd_gnt_d   = accept && (pick == OP_RD);
        wr_gnt_d   = accept && (pick == OP_WR);
        rd_valid_d = (state_q == DATA) && (state_d == GAP) && (op_q == OP_RD);
        wr_done_d  = (state_q == DATA) && (state_d == GAP) && (op_q == OP_WR);
    end

    always_ff @(posedge clkW or posedge resetAD) begin
        if (resetAD) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= OP_RD;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            bus_out_q  <= '0;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            busy_q     <= 1'b0;
            enw_q      <= 1'b0;
            c_ad_q     <= 1'b0;
            bus_oe_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            bus_out_q  <= bus_out_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            busy_q     <= busy_d;
            enw_q      <= enw_d;
            c_ad_q     <= c_ad_d;
            bus_oe_q   <= bus_oe_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign rd_gnt   = rd_gnt_q;
    assign wr_gnt   = wr_gnt_q;
    assign busy     = busy_q;
    assign enW      = enw_q;
    assign c_ad     = c_ad_q;
    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign wr_done  = wr_done_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: transaction table, hand-written
// corner sequences, random traffic against a transaction-offset model, and a
// second instance with GAP_LEN=1 / SAMPLE_IDX=2.
module tb_rtc_bus_sequencer;
    localparam int P = 23;
    localparam int G = 2;
    localparam int S = 12;

    logic       clkW = 1'b0;
    logic       resetAD = 1'b1;
    always #5 clkW = ~clkW;

    logic       rd_req = 0, wr_req = 0;
    logic [7:0] rd_addr = 0, wr_addr = 0, wr_data = 0, bus_in = 0;
    logic       rd_gnt, wr_gnt, busy, enW, c_ad, bus_oe, rd_valid, wr_done;
    logic [7:0] bus_out, rd_data;

    rtc_bus_sequencer #(.DW(8), .PHASE_LEN(P), .GAP_LEN(G), .SAMPLE_IDX(S)) dut (
        .clkW(clkW), .resetAD(resetAD), .rd_req(rd_req), .rd_addr(rd_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .busy(busy), .enW(enW), .c_ad(c_ad),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_done(wr_done));

    logic       rd_req2 = 0, wr_req2 = 0;
    logic [7:0] rd_addr2 = 8'h09, wr_addr2 = 8'h0A, wr_data2 = 8'h0B, bus_in2 = 0;
    logic       rd_gnt2, wr_gnt2, busy2, enW2, c_ad2, bus_oe2, rd_valid2, wr_done2;
    logic [7:0] bus_out2, rd_data2;

    rtc_bus_sequencer #(.DW(8), .PHASE_LEN(P), .GAP_LEN(1), .SAMPLE_IDX(2)) dut2 (
        .clkW(clkW), .resetAD(resetAD), .rd_req(rd_req2), .rd_addr(rd_addr2),
        .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_gnt(rd_gnt2), .wr_gnt(wr_gnt2), .busy(busy2), .enW(enW2), .c_ad(c_ad2),
        .bus_out(bus_out2), .bus_oe(bus_oe2), .bus_in(bus_in2), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .wr_done(wr_done2));

    int tests = 0, fails = 0, cyc = 0;

    // Model: m_k is the number of cycles since grant (-1 when idle).
    int         m_k = -1;
    bit         m_op = 0, m_last = 0;   // 1 = write
    logic [7:0] m_addr = 0, m_data = 0, m_rd = 0;

    task automatic m_reset();
        m_k = -1; m_op = 0; m_last = 0; m_addr = 0; m_data = 0; m_rd = 0;
    endtask

    task automatic m_edge();
        if (m_k < 0) begin
            if (rd_req || wr_req) begin
                m_op   = (rd_req && wr_req) ? !m_last : wr_req;
                m_last = m_op;
                m_addr = m_op ? wr_addr : rd_addr;
                m_data = wr_data;
                m_k    = 0;
            end
        end else begin
            if (!m_op && m_k == P + S) m_rd = bus_in;
            m_k = (m_k == 2*P + G - 1) ? -1 : m_k + 1;
        end
    endtask

    function automatic logic [23:0] expv();
        logic       ad, dt, act;
        logic [7:0] bo;
        act = (m_k >= 0);
        ad  = act && (m_k < P);
        dt  = (m_k >= P) && (m_k < 2*P);
        bo  = ad ? m_addr : ((dt && m_op) ? m_data : 8'h00);
        return {(m_k == 0) && !m_op, (m_k == 0) && m_op, act, ad || dt, ad,
                ad || (dt && m_op), bo, m_rd, (m_k == 2*P) && !m_op, (m_k == 2*P) && m_op};
    endfunction

    function automatic logic [23:0] actv();
        return {rd_gnt, wr_gnt, busy, enW, c_ad, bus_oe, bus_out, rd_data, rd_valid, wr_done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, a, e);
        end
    endtask

    task automatic step(input string nm);
        m_edge();
        @(posedge clkW); #1;
        cyc++;
        chk(nm, 32'(actv()), 32'(expv()));
    endtask

    typedef struct {
        bit         rd, wr;
        logic [7:0] ra, wa, wd, bin;
        bit         exp_wr;
        logic [7:0] exp_addr, exp_data;
        bit         exp_doe;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vt[6];
    int   last_gnt, wg_cnt, nw, nr, gapc, k2, wcyc, rcyc;
    logic [7:0] got2;

    initial begin
        // rd, wr, ra, wa, wd, bin, exp_wr, exp_addr, exp_data, exp_doe, exp_rd
        vt[0] = '{0, 1, 8'h00, 8'h21, 8'h5A, 8'h00, 1, 8'h21, 8'h5A, 1, 8'h00};
        vt[1] = '{1, 0, 8'h04, 8'h00, 8'h00, 8'h37, 0, 8'h04, 8'h00, 0, 8'h37};
        vt[2] = '{1, 1, 8'h10, 8'h20, 8'hAA, 8'h99, 1, 8'h20, 8'hAA, 1, 8'h37};
        vt[3] = '{1, 1, 8'h11, 8'h22, 8'hBB, 8'hC3, 0, 8'h11, 8'h00, 0, 8'hC3};
        vt[4] = '{1, 1, 8'h44, 8'h33, 8'hFF, 8'h12, 1, 8'h33, 8'hFF, 1, 8'hC3};
        vt[5] = '{1, 0, 8'hFE, 8'h00, 8'h00, 8'h00, 0, 8'hFE, 8'h00, 0, 8'h00};

        // Reset state
        m_reset();
        repeat (2) @(posedge clkW);
        #1;
        chk("reset_outputs", 32'(actv()), 32'h0);
        resetAD = 1'b0;

        // Table-driven transactions from reset
        last_gnt = 0;
        for (int i = 0; i < 6; i++) begin
            rd_req = vt[i].rd; wr_req = vt[i].wr;
            rd_addr = vt[i].ra; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            bus_in = ~vt[i].bin;
            step("tbl_grant_step");
            chk("tbl_gnt", {30'd0, rd_gnt, wr_gnt}, {30'd0, !vt[i].exp_wr, vt[i].exp_wr});
            chk("tbl_addr", {24'd0, bus_out}, {24'd0, vt[i].exp_addr});
            if (i > 0) chk("tbl_spacing", cyc - last_gnt, 2*P + G + 1);
            last_gnt = cyc;
            // Requests drop and inputs change after grant: must not matter.
            rd_req = 0; wr_req = 0;
            rd_addr = ~rd_addr; wr_addr = ~wr_addr; wr_data = ~wr_data;
            for (int c = 0; c < 2*P + G; c++) begin
                bus_in = (m_k >= P + 10 && m_k <= P + 14) ? vt[i].bin : ~vt[i].bin;
                step("tbl_cycle");
                if (c == P - 1)
                    chk("tbl_data_phase", {22'd0, c_ad, bus_oe, bus_out},
                        {22'd0, 1'b0, vt[i].exp_doe, vt[i].exp_data});
                if (c == 2*P - 1)
                    chk("tbl_complete", {22'd0, rd_valid, wr_done, rd_data},
                        {22'd0, !vt[i].exp_wr, vt[i].exp_wr, vt[i].exp_rd});
            end
        end

        // Write pulsed for one cycle during a busy read is dropped.
        step("idle_gap");
        rd_req = 1; rd_addr = 8'h05;
        step("pulse_rd_grant");
        rd_req = 0;
        wg_cnt = 0;
        repeat (10) step("pulse_busy");
        wr_req = 1; wr_addr = 8'h77; wr_data = 8'h88;
        step("pulse_wr_high");
        wr_req = 0;
        for (int c = 0; c < 2*P + G + 5; c++) begin
            step("pulse_drain");
            if (wr_gnt) wg_cnt++;
        end
        chk("pulse_no_wr_gnt", wg_cnt, 0);

        // Reset at DATA cycle 5 of a write, request held throughout.
        wr_req = 1; wr_addr = 8'h66; wr_data = 8'h77;
        step("rst_grant");
        while (m_k < P + 5) step("rst_run");
        #2 resetAD = 1'b1;
        #1;
        chk("rst_async", {28'd0, enW, bus_oe, busy, wr_done}, 32'h0);
        m_reset();
        @(posedge clkW); #1;
        cyc++;
        chk("rst_held", 32'(actv()), 32'(expv()));
        resetAD = 1'b0;
        step("rst_regrant");
        chk("rst_regrant_wr", {30'd0, rd_gnt, wr_gnt}, 32'h1);
        wr_req = 0;
        repeat (2*P + G + 1) step("rst_rewrite");

        // Random traffic against the model
        for (int c = 0; c < 2500; c++) begin
            rd_req  = ($urandom_range(0, 3) == 0);
            wr_req  = ($urandom_range(0, 3) == 0);
            rd_addr = 8'($urandom);
            wr_addr = 8'($urandom);
            wr_data = 8'($urandom);
            bus_in  = 8'($urandom);
            step("rand");
        end
        rd_req = 0; wr_req = 0;

        // GAP_LEN=1, SAMPLE_IDX=2 instance: write then read with both held.
        rd_req2 = 1; wr_req2 = 1;
        k2 = -1000; nw = 0; nr = 0; gapc = 0; got2 = 0; wcyc = 0; rcyc = 0;
        for (int c = 0; c < 160; c++) begin
            bus_in2 = (k2 == P + 2) ? 8'h5C : 8'hA3;
            @(posedge clkW); #1;
            if (k2 >= 0) k2++;
            if (wr_gnt2) begin wr_req2 = 0; nw++; wcyc = c; end
            if (rd_gnt2) begin rd_req2 = 0; nr++; rcyc = c; k2 = 0; end
            if (busy2 && !enW2) gapc++;
            if (rd_valid2) got2 = rd_data2;
        end
        chk("ovr_grants", {16'd0, 8'(nw), 8'(nr)}, 32'h0101);
        chk("ovr_spacing", rcyc - wcyc, 2*P + 1 + 1);
        chk("ovr_gap_cycles", gapc, 2);
        chk("ovr_sample_idx2", {24'd0, got2}, 32'h5C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
